mem_line_access_ctrl: RTL and testbench
=======================================

# mem_line_access_ctrl

Parametrised data-memory access sequencer for the MEM stage. It turns one pipeline memory request into one or two Wishbone line transactions: direct, or indirect (pointer fetch then final access). It covers word and byte lanes over a configurable line width and retries on RTY. It raises `busy` to the pipeline control arbiter until the access completes.

## Interface
Parameters:
- `LINE_WORDS`, 8: 16-bit words per Wishbone line; power of two, 2..32.
- `ADDR_W`, 16: byte-address width.
- `MAX_RETRY`, 15: RTY responses tolerated per transaction phase; only used when the retry limit is compiled in.

Derived: `OFS_W = log2(LINE_WORDS)+1` byte-offset bits.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: pipeline stall; holds the DONE state.
- `req_valid` in 1: a memory access is requested by the instruction in MEM; held stable while `busy`.
- `req_we` in 1: 1 = store (final phase only).
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_indirect` in 1: 1 = fetch a word pointer at `req_addr` first.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 16: store data; byte stores use `[7:0]`.
- `busy` out 1: stall request to the pipeline.
- `done` out 1: one-cycle pulse on completion.
- `rdata` out 16: load result, registered.
- `error` out 1: retry limit exceeded, sticky until next request.
- `wb_adr` out ADDR_W-OFS_W: line address.
- `wb_cyc`, `wb_stb`, `wb_we` out 1: Wishbone controls.
- `wb_sel` out 2*LINE_WORDS: byte enables.
- `wb_dat_m` out 16*LINE_WORDS: write line.
- `wb_dat_s` in 16*LINE_WORDS: read line.
- `wb_ack`, `wb_rty` in 1: slave responses.

## Operation
- States: IDLE, PTR (pointer read), ACC (final access), DONE.
- IDLE: when `req_valid` is high and `rst` is low, go to PTR if `req_indirect`, else to ACC.
- PTR:
  - Read the word at `req_addr`; `wb_we=0`.
  - On `wb_ack`, latch the word lane into `ptr_q` and go to ACC.
- ACC:
  - Effective address `ea = req_indirect ? ptr_q : req_addr`.
  - On `wb_ack`, capture the read lane into `rdata` (loads) or leave it unchanged (stores), then go to DONE.
- DONE:
  - `done` is high for exactly the entry cycle.
  - Stay in DONE while `stall=1`.
  - With `stall=0`, go to IDLE.
  - A new `req_valid` in the IDLE cycle starts a new access.
- Lane selection:
  - Word index `w = ea[OFS_W-1:1]`. `wb_adr = ea[ADDR_W-1:OFS_W]`.
  - Word access: `ea[0]` is ignored; `sel[2w+:2]=11`; `dat_m[16w+:16]=req_wdata`; `rdata = dat_s[16w+:16]`.
  - Byte access: `sel[2w+:2]` is `10` if `ea[0]`, else `01`; the byte is placed in the matching half of lane w; `rdata = {8'h00, dat_s[8*ea[OFS_W-1:0]+:8]}`.
  - All other `sel` and `dat_m` bits are 0.
- The pointer read is always a word access, regardless of `req_byte`.
- Wishbone controls:
  - `wb_cyc = wb_stb = 1` only in PTR and ACC.
  - `wb_we = req_we` only in ACC.
- RTY: stay in the current phase and re-issue next cycle. The per-phase retry counter clears on phase entry.
- ACK and RTY in the same cycle: ACK wins.
- `busy = req_valid & (state != DONE)`. It is combinational, so it is high already in the IDLE cycle that accepts the request.

## Timing
- Reset values: state IDLE; `rdata`, `ptr_q`, `error` and retry counter 0; all Wishbone outputs 0; `busy` follows `req_valid`.
- Asserting `rst` in any state drops `wb_cyc` and `wb_stb` asynchronously and abandons the transaction.
- Direct access, earliest completion:
  - Cycle 0: IDLE accepts.
  - Cycle 1: ACC, ack arrives.
  - Cycle 2: DONE; `busy=0`; `rdata` valid.
- Indirect access, earliest completion: DONE in cycle 3.
- Each RTY adds one cycle.
- `rdata` holds its value until the next load's ACK.

## Configuration
- `MEM_ACCESS_RETRY_LIMIT_EN` defined:
  - A retry counter of `log2(MAX_RETRY+1)` bits is built.
  - The (MAX_RETRY+1)th RTY in a phase sets `error` and goes directly to DONE; `rdata` is unchanged.
  - `error` clears when IDLE accepts the next request.
- Undefined: no counter is built; RTY retries indefinitely; `error` is tied to 0.

## Test plan
- Word load, `LINE_WORDS=8`, `req_addr=0x1237`, ACK in cycle 1 with word 3 = `0xBEEF` -> `wb_adr=0x123`, `wb_sel=0x00C0`, `rdata=0xBEEF`, `done` in cycle 2.
- Byte store, `req_addr=0x0045`, `req_wdata=0x12AB` -> `wb_sel=0x0020`, `wb_dat_m[47:40]=0xAB`, all other bits 0, `wb_we=1`.
- Indirect load at `0x0010`, pointer word 0 = `0x3002`, second line word 1 = `0x5A5A` -> second phase `wb_adr=0x300`, `wb_sel=0x000C`, `rdata=0x5A5A`, DONE in cycle 3.
- RTY for 3 cycles then ACK -> `wb_stb` high for 4 cycles, `error=0`. With the macro defined, `MAX_RETRY=2` and continuous RTY -> `error=1` and DONE after the 3rd RTY.
- `rst` pulsed while in ACC -> `wb_cyc` and `wb_stb` go to 0 in the same cycle; state IDLE; `rdata=0`.
- `stall=1` for 4 cycles in DONE -> `done` pulses once, `rdata` is held, and the state leaves DONE one cycle after `stall` falls.

Source files
------------

// File: rtl/mem_line_access_ctrl.sv
// mem_line_access_ctrl: MEM-stage data-memory access sequencer.
// Turns one pipeline request into one Wishbone line transaction (direct) or
// two (indirect: pointer word fetch, then the final access). It handles word
// and byte lanes over a LINE_WORDS x 16-bit line and re-issues on RTY.
// Optional feature macro: MEM_ACCESS_RETRY_LIMIT_EN. When it is defined, a
// per-phase RTY counter aborts the access with a sticky error after
// MAX_RETRY+1 retries.
module mem_line_access_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 16,
    parameter int MAX_RETRY  = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic                           req_byte,
    input  logic                           req_indirect,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [15:0]                    req_wdata,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    rdata,
    output logic                           error,
    output logic [ADDR_W-$clog2(LINE_WORDS)-2:0] wb_adr,
    output logic                           wb_cyc,
    output logic                           wb_stb,
    output logic                           wb_we,
    output logic [2*LINE_WORDS-1:0]        wb_sel,
    output logic [16*LINE_WORDS-1:0]       wb_dat_m,
    input  logic [16*LINE_WORDS-1:0]       wb_dat_s,
    input  logic                           wb_ack,
    input  logic                           wb_rty
);

    localparam int OFS_W = $clog2(LINE_WORDS) + 1;
    localparam int SEL_W = 2 * LINE_WORDS;
    localparam int DAT_W = 16 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        ACC,
        DONE
    } state_t;

    state_t          state;
    logic [15:0]     ptr_q;

    logic            accept;
    logic            ptr_ack;
    logic            acc_ack;
    logic            rty_hit;
    logic            give_up;
    logic            to_done;

    logic [ADDR_W-1:0] cur_ea;
    logic [15:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       load_val;

    logic [ADDR_W-1:0] nxt_ea;
    logic              nxt_byte;
    logic [OFS_W-2:0]  nxt_w;
    logic [SEL_W-1:0]  nxt_sel;
    logic [DAT_W-1:0]  nxt_dat;

    assign accept  = (state == IDLE) && req_valid;
    assign ptr_ack = (state == PTR) && wb_ack;
    assign acc_ack = (state == ACC) && wb_ack;
    // ACK takes priority, so an RTY only counts when no ACK is present.
    assign rty_hit = ((state == PTR) || (state == ACC)) && wb_rty && !wb_ack;
    assign to_done = acc_ack || give_up;

    // The stall request is combinational so it is already high in the
    // accepting IDLE cycle.
    assign busy = req_valid && (state != DONE);

    // Read-lane extraction for the phase currently on the bus.
    always_comb begin
        cur_ea   = ((state == ACC) && req_indirect) ? ADDR_W'(ptr_q) : req_addr;
        rd_word  = wb_dat_s[16*cur_ea[OFS_W-1:1] +: 16];
        rd_byte  = wb_dat_s[8*cur_ea[OFS_W-1:0] +: 8];
        load_val = req_byte ? {8'h00, rd_byte} : rd_word;
    end

    // Lane drive for the phase about to start: the first phase uses req_addr
    // (word-only when it is a pointer fetch), the final indirect phase uses
    // the pointer arriving on the bus this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        nxt_sel  = '0;
        nxt_dat  = '0;
        nxt_ea   = (state == PTR) ? ADDR_W'(rd_word) : req_addr;
        nxt_byte = (state == PTR) ? req_byte : (req_byte && !req_indirect);
        nxt_w    = nxt_ea[OFS_W-1:1];
        if (nxt_byte) begin
            nxt_sel[2*nxt_w +: 2]  = nxt_ea[0] ? 2'b10 : 2'b01;
            nxt_dat[16*nxt_w +: 16] = nxt_ea[0] ? {req_wdata[7:0], 8'h00}
                                                 : {8'h00, req_wdata[7:0]};
        end else begin
            nxt_sel[2*nxt_w +: 2]   = 2'b11;
            nxt_dat[16*nxt_w +: 16] = req_wdata;
        end
    end

`ifdef MEM_ACCESS_RETRY_LIMIT_EN
    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RC_W-1:0] retry_cnt;
    logic            error_q;

    assign give_up = rty_hit && (retry_cnt == RC_W'(MAX_RETRY));
    assign error   = error_q;

    // Per-phase RTY counter, cleared whenever a bus phase starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (accept || ptr_ack) begin
            retry_cnt <= '0;
        end else if (rty_hit && !give_up) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // Sticky abort flag, cleared by the next accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (give_up) begin
            error_q <= 1'b1;
        end
    end
`else
    assign give_up = 1'b0;
    assign error   = 1'b0;
`endif

    // Sequencer FSM with registered Wishbone outputs, done pulse and load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr_q    <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_sel   <= '0;
            wb_dat_m <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the pre-edge values of the whole block.
            done <= 1'b0;
            if (accept) begin
                state    <= req_indirect ? PTR : ACC;
                wb_cyc   <= 1'b1;
                wb_stb   <= 1'b1;
                wb_we    <= req_we && !req_indirect;
                wb_adr   <= nxt_ea[ADDR_W-1:OFS_W];
                wb_sel   <= nxt_sel;
                wb_dat_m <= nxt_dat;
            end else if (ptr_ack) begin
                state    <= ACC;
                ptr_q    <= rd_word;
                wb_we    <= req_we;
                wb_adr   <= nxt_ea[ADDR_W-1:OFS_W];
                wb_sel   <= nxt_sel;
                wb_dat_m <= nxt_dat;
            end else if (to_done) begin
                state    <= DONE;
                done     <= 1'b1;
                wb_cyc   <= 1'b0;
                wb_stb   <= 1'b0;
                wb_we    <= 1'b0;
                wb_adr   <= '0;
                wb_sel   <= '0;
                wb_dat_m <= '0;
                if (acc_ack && !req_we) begin
                    rdata <= load_val;
                end
            end else if ((state == DONE) && !stall) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_line_access_ctrl.sv
// tb_mem_line_access_ctrl: randomized self-checking bench for
// mem_line_access_ctrl with LINE_WORDS=8, ADDR_W=16, MAX_RETRY=2. The bench
// acts as the Wishbone slave and predicts every output from the lane rules
// using plain shifts on the line value. Build with MEM_ACCESS_RETRY_LIMIT_EN
// defined to exercise the retry-limit abort.
module tb_mem_line_access_ctrl;

    localparam int LW     = 8;
    localparam int AW     = 16;
`ifdef MEM_ACCESS_RETRY_LIMIT_EN
    localparam int LIM    = 2;
`else
    localparam int LIM    = -1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          req_valid;
    logic          req_we;
    logic          req_byte;
    logic          req_indirect;
    logic [15:0]   req_addr;
    logic [15:0]   req_wdata;
    logic          busy;
    logic          done;
    logic [15:0]   rdata;
    logic          error;
    logic [11:0]   wb_adr;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [15:0]   wb_sel;
    logic [127:0]  wb_dat_m;
    logic [127:0]  wb_dat_s;
    logic          wb_ack;
    logic          wb_rty;

    int errors = 0;
    int checks = 0;

    logic [15:0] rd_exp  = '0;
    logic        err_exp = 1'b0;

    mem_line_access_ctrl #(
        .LINE_WORDS (LW),
        .ADDR_W     (AW),
        .MAX_RETRY  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_byte     (req_byte),
        .req_indirect (req_indirect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .error        (error),
        .wb_adr       (wb_adr),
        .wb_cyc       (wb_cyc),
        .wb_stb       (wb_stb),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_dat_m     (wb_dat_m),
        .wb_dat_s     (wb_dat_s),
        .wb_ack       (wb_ack),
        .wb_rty       (wb_rty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete access. rp/ra are the RTY counts the slave gives before
    // ACK in the pointer and final phase; st is the number of stalled cycles
    // spent in DONE after its entry cycle.
    task automatic access(input bit we, input bit bt, input bit ind,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] ptr,
                          input logic [127:0] lptr, input logic [127:0] lacc,
                          input int rp, input int ra, input int st);
        logic [15:0]  ea;
        logic [127:0] line;
        logic [127:0] sel_e;
        logic [127:0] dat_e;
        logic [127:0] sh;
        bit           ebyte;
        bit           gave_up;
        int           nr;
        gave_up = 1'b0;

        // Cycle 0: IDLE accepts the request.
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_byte = bt; req_indirect = ind;
        req_addr = addr; req_wdata = wdata; stall = 1'b0;
        wb_ack = 1'b0; wb_rty = 1'b0; wb_dat_s = rand128();
        #1;
        check("busy_accept", busy, 1'b1);
        check("cyc_idle", wb_cyc, 1'b0);
        check("err_before", error, err_exp);
        err_exp = 1'b0;

        for (int ph = (ind ? 0 : 1); ph < 2 && !gave_up; ph++) begin
            ea    = (ph == 0) ? addr : (ind ? ptr : addr);
            ebyte = (ph == 1) && bt;
            nr    = (ph == 0) ? rp : ra;
            line  = (ph == 0) ? lptr : lacc;
            if (ph == 0) line[16*addr[3:1] +: 16] = ptr;
            sel_e = ebyte ? (128'h1 << ea[3:0]) : (128'h3 << (2*ea[3:1]));
            dat_e = ebyte ? (128'(wdata[7:0]) << (8*ea[3:0]))
                          : (128'(wdata) << (16*ea[3:1]));
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                if (c < nr) begin
                    wb_ack = 1'b0; wb_rty = 1'b1; wb_dat_s = rand128();
                end else begin
                    wb_ack = 1'b1; wb_rty = ($urandom_range(0, 3) == 0); wb_dat_s = line;
                end
                #1;
                check("cyc", wb_cyc, 1'b1);
                check("stb", wb_stb, 1'b1);
                check("we", wb_we, (ph == 1) && we);
                check("adr", wb_adr, ea[15:4]);
                check("sel", wb_sel, sel_e);
                check("dat_m", wb_dat_m, dat_e);
                check("busy_phase", busy, 1'b1);
                check("done_phase", done, 1'b0);
                check("err_phase", error, 1'b0);
                if (c >= nr) begin
                    if (ph == 1 && !we) begin
                        sh = ebyte ? (line >> (8*ea[3:0])) : (line >> (16*ea[3:1]));
                        rd_exp = ebyte ? {8'h00, sh[7:0]} : sh[15:0];
                    end
                    break;
                end
                if (LIM >= 0 && c == LIM) begin
                    gave_up = 1'b1;
                    err_exp = 1'b1;
                    break;
                end
            end
        end

        // DONE entry cycle.
        @(negedge clk);
        wb_ack = 1'b0; wb_rty = 1'b0; wb_dat_s = rand128();
        stall = (st > 0);
        #1;
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b0);
        check("cyc_done", wb_cyc, 1'b0);
        check("stb_done", wb_stb, 1'b0);
        check("rdata", rdata, rd_exp);
        check("error", error, err_exp);
        for (int i = 1; i <= st; i++) begin
            @(negedge clk);
            stall = (i < st);
            #1;
            check("done_held_low", done, 1'b0);
            check("busy_stall", busy, 1'b0);
            check("rdata_stall", rdata, rd_exp);
        end
    endtask

    // Reset pulse while the final access is on the bus.
    task automatic reset_in_acc(input logic [15:0] addr);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_indirect = 1'b0;
        req_addr = addr; req_wdata = 16'h0; stall = 1'b0;
        wb_ack = 1'b0; wb_rty = 1'b0;
        @(negedge clk);
        #1;
        check("rst_pre_cyc", wb_cyc, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_sel", wb_sel, 16'h0);
        check("rst_busy", busy, 1'b1);
        rd_exp  = '0;
        err_exp = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_idle_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
    endtask

    initial begin : stim
        logic [127:0] l;
        logic [15:0]  p;
        rst = 1'b1; stall = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0;
        req_indirect = 1'b0; req_addr = '0; req_wdata = '0;
        wb_dat_s = '0; wb_ack = 1'b0; wb_rty = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 1'b1);
        check("reset_cyc", wb_cyc, 1'b0);
        check("reset_stb", wb_stb, 1'b0);
        check("reset_we", wb_we, 1'b0);
        check("reset_sel", wb_sel, 16'h0);
        check("reset_dat_m", wb_dat_m, 128'h0);
        check("reset_adr", wb_adr, 12'h0);
        check("reset_rdata", rdata, 16'h0);
        check("reset_error", error, 1'b0);
        check("reset_done", done, 1'b0);
        req_valid = 1'b0;
        rst = 1'b0;

        // Word load: line word 3 holds 0xBEEF.
        l = rand128(); l[63:48] = 16'hBEEF;
        access(1'b0, 1'b0, 1'b0, 16'h1237, 16'h0000, 16'h0, '0, l, 0, 0, 0);
        // Byte store with a 4-cycle stall in DONE.
        access(1'b1, 1'b1, 1'b0, 16'h0045, 16'h12AB, 16'h0, '0, rand128(), 0, 0, 4);
        // Indirect load through pointer 0x3002; target word 1 holds 0x5A5A.
        l = rand128(); l[31:16] = 16'h5A5A;
        access(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h3002, rand128(), l, 0, 0, 0);
        // RTY three times, then ACK.
        access(1'b0, 1'b1, 1'b0, 16'h2223, 16'h0000, 16'h0, '0, rand128(), 0, 3, 1);
        // Long RTY run on both phases of an indirect load.
        access(1'b0, 1'b0, 1'b1, 16'h0102, 16'h0000, 16'h4444, rand128(), rand128(), 5, 4, 0);
        // A successful load after any abort clears the error.
        access(1'b0, 1'b0, 1'b0, 16'h0F0E, 16'h0000, 16'h0, '0, rand128(), 0, 0, 0);
        reset_in_acc(16'h7776);

        for (int n = 0; n < 60; n++) begin
            p = 16'($urandom);
            access(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   p, rand128(), rand128(), $urandom_range(0, 3), $urandom_range(0, 4),
                   $urandom_range(0, 3));
        end

        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
